// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 lines, deframes
// 11-bit frames, folds E0/F0 prefixes into key events and queues them in a show-ahead FIFO.
module ps2_scan_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_code,
  output logic                          out_brk,
  output logic                          out_ext,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          par_err,
  output logic                          frame_err,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  // ---------------------------------------------------------------------------
  // Synchroniser and glitch filter; bit 0 = ps2_clk, bit 1 = ps2_data
  // ---------------------------------------------------------------------------
  logic [1:0]    line_in;
  logic [1:0]    meta_q;
  logic [1:0]    sync_q;
  logic [1:0]    filt_q;
  logic [FW-1:0] flt_cnt_q [2];
  logic          clk_prev_q;
  logic          fall;
  logic          bit_in;

  assign line_in = {ps2_data, ps2_clk};

  // A level change is accepted only after FILTER_LEN consecutive samples differ
  // from the current filtered level; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= '1;
      sync_q     <= '1;
      filt_q     <= '1;
      clk_prev_q <= 1'b1;
      for (int i = 0; i < 2; i++) flt_cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value,
      // so meta_q -> sync_q behaves as two stages and not as one wire.
      meta_q     <= line_in;
      sync_q     <= meta_q;
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          flt_cnt_q[i] <= '0;
        end else if (flt_cnt_q[i] == FW'(FILTER_LEN - 1)) begin
          filt_q[i]    <= sync_q[i];
          flt_cnt_q[i] <= '0;
        end else begin
          flt_cnt_q[i] <= flt_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign fall   = clk_prev_q & ~filt_q[0];
  assign bit_in = filt_q[1];

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          timeout;
  logic          shift_en, par_en, stop_en;
  logic          byte_ok, parity_bad, frame_bad;

  assign timeout = (state_q != IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      unique case (state_q)
        IDLE:    if (!bit_in) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: every signal written here gets a default first, so no latch can be
  // inferred on a path that does not assign it.
  always_comb begin
    shift_en   = 1'b0;
    par_en     = 1'b0;
    stop_en    = 1'b0;
    byte_ok    = 1'b0;
    parity_bad = 1'b0;
    frame_bad  = timeout;
    if (fall) begin
      shift_en = (state_q == DATA);
      par_en   = (state_q == PARITY);
      stop_en  = (state_q == STOP);
    end
    if (stop_en) begin
      // A bad stop bit outranks a bad parity bit.
      if (!bit_in)                  frame_bad  = 1'b1;
      else if (^shift_q ^ par_q)    byte_ok    = 1'b1;
      else                          parity_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      if (state_q == IDLE)  bit_cnt_q <= '0;
      else if (shift_en)    bit_cnt_q <= bit_cnt_q + 1'b1;
      if (shift_en)         shift_q   <= {bit_in, shift_q[7:1]};
      if (par_en)           par_q     <= bit_in;
      if (state_q == IDLE || fall) tmo_q <= '0;
      else                         tmo_q <= tmo_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame result pulses and prefix decoder
  // ---------------------------------------------------------------------------
  logic       byte_vld_q;
  logic [7:0] byte_q;
  logic       ext_pend_q, brk_pend_q;
  logic       is_e0, is_f0, push;
  key_evt_t   new_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      par_err    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_vld_q <= byte_ok;
      byte_q     <= shift_q;
      par_err    <= parity_bad;
      frame_err  <= frame_bad;
    end
  end

  assign is_e0   = (byte_q == 8'hE0);
  assign is_f0   = (byte_q == 8'hF0);
  assign push    = byte_vld_q && !is_e0 && !is_f0;
  assign new_evt = '{ext: ext_pend_q, brk: brk_pend_q, code: byte_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else if (par_err || frame_err) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else if (byte_vld_q) begin
      if (is_e0) begin
        ext_pend_q <= 1'b1;
      end else if (is_f0) begin
        brk_pend_q <= 1'b1;
      end else begin
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead event FIFO
  // ---------------------------------------------------------------------------
  key_evt_t        mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            full, pop, wr_en;
  key_evt_t        head;

  assign full      = (fill == (AW + 1)'(FIFO_DEPTH));
  assign out_valid = (fill != '0);
  assign pop       = out_valid && out_ready;
  assign wr_en     = push && (!full || pop);

  // NOTE: the storage array has no reset; the head is only exposed while
  // out_valid=1, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= new_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill     <= '0;
      ovf      <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && !pop)      fill <= fill + 1'b1;
      else if (!wr_en && pop) fill <= fill - 1'b1;
      if (push && full && !pop) ovf <= 1'b1;
      else if (ovf_clr)         ovf <= 1'b0;
    end
  end

  assign head     = mem[rd_ptr_q];
  assign out_code = out_valid ? head.code : 8'h00;
  assign out_brk  = out_valid & head.brk;
  assign out_ext  = out_valid & head.ext;

endmodule
